// File: rtl/uart_tx_framer_if.sv
// Byte-request / serial-line bundle between a UART transmit client and uart_tx_framer.
interface uart_tx_framer_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
);
  logic [DATA_WIDTH-1:0]     p_data;
  logic                      data_valid;
  logic                      par_en;
  logic                      par_typ;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic                      tx_out;
  logic                      busy;

  modport master (
    output p_data, data_valid, par_en, par_typ, prescale,
    input  tx_out, busy
  );

  modport slave (
    input  p_data, data_valid, par_en, par_typ, prescale,
    output tx_out, busy
  );
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmitter: start / DATA_WIDTH data bits LSB first / optional parity / stop,
// each bit held for a latched number of clocks; tx_out and busy are registered.
module uart_tx_framer #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input logic             clk,
  input logic             rst,
  uart_tx_framer_if.slave bus
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                    state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
  logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic                      par_en_q, par_en_d;
  logic                      par_bit_q, par_bit_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;

  logic                      bit_done;
  logic [IDX_W-1:0]          idx_nxt;

  assign bit_done = (cnt_q == PRESCALE_WIDTH'(pre_q - PRESCALE_WIDTH'(1)));
  assign idx_nxt  = IDX_W'(idx_q + IDX_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pre_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pre_q     <= pre_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pre_d     = pre_q;
    idx_d     = idx_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_d      = tx_q;
    busy_d    = busy_q;

    if (state_q == IDLE) begin
      // Parity is fixed at acceptance so later par_typ changes cannot leak into the frame.
      if (bus.data_valid && (bus.prescale != '0)) begin
        data_d    = bus.p_data;
        par_en_d  = bus.par_en;
        par_bit_d = (^bus.p_data) ^ bus.par_typ;
        pre_d     = bus.prescale;
        cnt_d     = '0;
        idx_d     = '0;
        tx_d      = 1'b0;
        busy_d    = 1'b1;
        state_d   = START;
      end
    end else if (!bit_done) begin
      cnt_d = PRESCALE_WIDTH'(cnt_q + PRESCALE_WIDTH'(1));
    end else begin
      cnt_d = '0;
      unique case (state_q)
        START: begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = data_q[0];
        end
        DATA: begin
          if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_nxt;
            tx_d  = data_q[idx_nxt];
          end
        end
        PARITY: begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
        STOP: begin
          state_d = IDLE;
          busy_d  = 1'b0;
          tx_d    = 1'b1;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

  assign bus.tx_out = tx_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: expected line sequences are hand-derived bit patterns.
module tb_uart_tx_framer;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  uart_tx_framer_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) bus ();

  uart_tx_framer #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // seq holds the frame in time order from bit 10 downward (bit 10 = start bit).
  task automatic check_frame(input logic [10:0] seq, input int nbits, input int p,
                             input string tag, input int inject);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < p; c++) begin
        @(negedge clk);
        n_tests++;
        assert (bus.tx_out === seq[10-b])
          else begin
            n_fail++;
            $error("FAIL %s bit%0d cyc%0d tx_out=%b expected=%b", tag, b, c, bus.tx_out, seq[10-b]);
          end
        n_tests++;
        assert (bus.busy === 1'b1)
          else begin
            n_fail++;
            $error("FAIL %s_busy bit%0d cyc%0d busy=%b expected=1", tag, b, c, bus.busy);
          end
        if (inject >= 0 && (b * p + c) == inject) begin
          bus.p_data     = 8'hFF;
          bus.prescale   = 6'd16;
          bus.data_valid = 1'b1;
        end else if (inject >= 0 && (b * p + c) == inject + 1) begin
          bus.data_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic check_idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_tests++;
      assert (bus.tx_out === 1'b1 && bus.busy === 1'b0)
        else begin
          n_fail++;
          $error("FAIL %s cyc%0d tx_out=%b busy=%b expected tx_out=1 busy=0", tag, i, bus.tx_out, bus.busy);
        end
    end
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] p);
    @(negedge clk);
    bus.p_data     = d;
    bus.par_en     = pe;
    bus.par_typ    = pt;
    bus.prescale   = p;
    bus.data_valid = 1'b1;
    @(posedge clk);
    #1 bus.data_valid = 1'b0;
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    rst            = 1'b0;
    bus.p_data     = '0;
    bus.data_valid = 1'b0;
    bus.par_en     = 1'b0;
    bus.par_typ    = 1'b0;
    bus.prescale   = 6'd8;

    check_idle(3, "reset");
    @(negedge clk) rst = 1'b1;
    check_idle(3, "post_reset");

    // 0x33 even parity, P=8: parity 0
    send(8'h33, 1'b1, 1'b0, 6'd8);
    check_frame(11'b0_11001100_0_1, 11, 8, "t1_33_even", -1);
    check_idle(3, "t1_end");

    // 0xA5 no parity, P=16 (last vector bit unused)
    send(8'hA5, 1'b0, 1'b0, 6'd16);
    check_frame(11'b0_10100101_1_0, 10, 16, "t2_a5_nopar", -1);
    check_idle(3, "t2_end");

    // 0x23 odd parity, P=32: three ones -> parity 0
    send(8'h23, 1'b1, 1'b1, 6'd32);
    check_frame(11'b0_11000100_0_1, 11, 32, "t3_23_odd", -1);
    check_idle(3, "t3_end");

    // 0x55 even, P=8, with a 0xFF request and prescale change at clock 20
    send(8'h55, 1'b1, 1'b0, 6'd8);
    check_frame(11'b0_10101010_0_1, 11, 8, "t4_55_ignore", 20);
    check_idle(20, "t4_no_second");

    // Reset asserted at clock 30 of an all-zero frame
    send(8'h00, 1'b0, 1'b0, 6'd8);
    for (int i = 0; i < 30; i++) @(negedge clk);
    n_tests++;
    assert (bus.tx_out === 1'b0 && bus.busy === 1'b1)
      else begin
        n_fail++;
        $error("FAIL t5_pre tx_out=%b busy=%b expected tx_out=0 busy=1", bus.tx_out, bus.busy);
      end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    assert (bus.tx_out === 1'b1 && bus.busy === 1'b0)
      else begin
        n_fail++;
        $error("FAIL t5_async tx_out=%b busy=%b expected tx_out=1 busy=0", bus.tx_out, bus.busy);
      end
    @(negedge clk) rst = 1'b1;
    check_idle(20, "t5_stay_idle");

    // Back-to-back with data_valid held: 0x3C odd (parity 1) then 0x33 even
    @(negedge clk);
    bus.p_data     = 8'h3C;
    bus.par_en     = 1'b1;
    bus.par_typ    = 1'b1;
    bus.prescale   = 6'd8;
    bus.data_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.p_data  = 8'h33;
    bus.par_typ = 1'b0;
    check_frame(11'b0_00111100_1_1, 11, 8, "t6_3c_odd", -1);
    check_idle(1, "t6_gap");
    @(posedge clk);
    #1 bus.data_valid = 1'b0;
    check_frame(11'b0_11001100_0_1, 11, 8, "t6_33_even", -1);
    check_idle(3, "t6_end");

    // prescale=0 requests are ignored
    @(negedge clk);
    bus.prescale   = 6'd0;
    bus.data_valid = 1'b1;
    check_idle(6, "t7_prescale0");
    bus.data_valid = 1'b0;
    check_idle(2, "t7_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
